cache_l1_nway: RTL and testbench
================================

Name: cache_l1_nway

Overview:
- Parametrised N-way set-associative L1 cache with 32-byte lines. It supersedes single-way storage with a complete tag/valid/dirty/data store, tree pseudo-LRU replacement and a write-back miss controller.
- Sits between the CPU pipeline port (word requests) and the L2/arbiter port (256-bit line transfers).
- Write-back, write-allocate.

Parameters:
- SETS, 8, number of sets; power of 2, at least 2.
- WAYS, 4, associativity; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp; never asserted together with mem_read
- mem_address  in  32  CPU byte address; bits [1:0] ignored
- mem_wdata  in  32  CPU write word
- mem_byte_enable  in  4  byte mask for writes
- mem_rdata  out  32  read word; valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_address  out  32  line-aligned address; [4:0]=0
- pmem_wdata  out  256  victim line
- pmem_rdata  in  256  fill line
- pmem_resp  in  1  lower-level completion pulse

Behaviour:
- Address split:
  - offset = [4:0]
  - index = [5+log2(SETS)-1:5]
  - tag = remaining upper bits; width TAG_W = 27-log2(SETS)
- Storage is flop-based with combinational read by index.
  - Valid, dirty and PLRU bits reset to 0.
  - Data and tag arrays are not reset.
- Reset outputs: mem_resp=0, pmem_read=0, pmem_write=0, mem_rdata=0, pmem_address=0, pmem_wdata=0. FSM enters CMP.
- FSM states: CMP, WB, FILL.
- CMP:
  - Idle when neither request is asserted; all outputs are 0.
  - Hit when any way has valid=1 and a matching tag. Matches are one-hot by construction.
  - Read hit: mem_resp=1 in the same cycle; mem_rdata = addressed word of the hit line.
  - Write hit: mem_resp=1; bytes selected by mem_byte_enable are merged into the word at offset[4:2] on the clock edge; dirty=1.
  - Every hit updates PLRU for that set to point away from the hit way.
  - Miss victim selection: lowest-index invalid way if one exists, else the PLRU way. The victim is latched in a register.
  - Miss with dirty victim goes to WB. Clean or invalid victim goes to FILL.
- WB:
  - pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line.
  - Stays in WB until pmem_resp, then goes to FILL.
  - Victim dirty is cleared on exit.
- FILL:
  - pmem_read=1, pmem_address={tag, index, 5'b0}.
  - On pmem_resp: write pmem_rdata into the victim way, write tag, valid=1, dirty=0, then go to CMP.
  - The request then hits next cycle; a write applies its merge then.
- Latency:
  - Hit: 0 extra cycles (response in the request cycle).
  - Clean miss: fill latency + 1.
  - Dirty miss: WB latency + fill latency + 1.
- mem_resp is asserted only in CMP. pmem_read and pmem_write are never asserted together.
- pmem_resp outside WB/FILL is ignored.
- The CPU request and address are stable across the whole miss; this is CPU-side contract, not checked.
- PLRU is a binary tree of WAYS-1 bits per set.
  - Access to a way sets each node on its path to point to the opposite subtree.
  - Victim walk follows node bits (0 = left, 1 = right).
- Reset mid-miss: pmem_read and pmem_write drop asynchronously. All lines become invalid, including dirty ones, so their data is lost. This is intended.
- All ways invalid in a set: way 0 is filled first, then ways 1..WAYS-1 in order.

Decomposition:
- Shared package rv32i_types holds rv32i_word, rv32i_cache_line, rv32i_mem_wmask and a new constant CACHE_OFFSET_W=5.
- Sub-module plru_tree #(WAYS):
  - Combinational.
  - Inputs: node bits, access way.
  - Outputs: updated node bits, victim way.
  - Instantiated once on the indexed set.
- Word merge and word select logic stay inline.

Test Plan:
- Cold read at 0x0000_0040, SETS=8, WAYS=4 -> one FILL at 0x40. After pmem_resp with line word2=0xDEADBEEF, the next read of 0x48 returns 0xDEADBEEF with 0-cycle latency and no pmem activity.
- Write hit at 0x48, data 0x11223344, mask 4'b0011 -> a subsequent read of 0x48 returns 0xDEAD3344; that line's dirty=1.
- Five distinct tags mapping to set 2 (0x040, 0x140, 0x240, 0x340, 0x440) -> ways 0..3 fill in order. The fifth evicts PLRU way 0 after the access order 0,1,2,3; no WB because all are clean.
- Dirty eviction: write 0x040, then fill 0x140..0x440 -> pmem_write at 0x040 with the merged line precedes pmem_read at 0x440.
- PLRU after hit: fill ways 0..3 in set 2, re-read 0x040 (way 0) -> the next miss evicts way 2, not way 0.
- Assert rst during WB wait -> pmem_write=0 immediately. After release, a read of any prior address misses and refills.

Source files
------------

// File: rtl/cache_l1_nway_pkg.sv
// Shared RV32I memory-side types and the L1 cache controller state encoding.
package rv32i_types;

    typedef logic [31:0]  rv32i_word;
    typedef logic [255:0] rv32i_cache_line;
    typedef logic [3:0]   rv32i_mem_wmask;

    localparam int CACHE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        ST_CMP  = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2
    } cache_state_e;

endpackage

// File: rtl/cache_l1_nway_plru_tree.sv
// Tree pseudo-LRU for one set: node 0 is the root, children of n are 2n+1 / 2n+2.
// A node bit of 0 points left, 1 points right.
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         nodes_i,
    input  logic [$clog2(WAYS)-1:0] access_way_i,
    output logic [WAYS-2:0]         nodes_o,
    output logic [$clog2(WAYS)-1:0] victim_o
);

    localparam int LOG = $clog2(WAYS);

    logic [WAYS-1:0] vic_vec;

    for (genvar n = 0; n < WAYS - 1; n++) begin : g_node
        localparam int D   = $clog2(n + 2) - 1;
        localparam int POS = n + 1 - (1 << D);
        logic on_path;
        assign on_path    = ((int'(access_way_i) >> (LOG - D)) == POS);
        assign nodes_o[n] = on_path ? ~access_way_i[LOG-D-1] : nodes_i[n];
    end

    // A way is the victim when every node on its path points toward it.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [LOG-1:0] m;
        for (genvar d = 0; d < LOG; d++) begin : g_lvl
            localparam int N = (1 << d) - 1 + (w >> (LOG - d));
            localparam int B = (w >> (LOG - 1 - d)) & 1;
            assign m[d] = (nodes_i[N] == 1'(B));
        end
        assign vic_vec[w] = &m;
    end

    always_comb begin
        victim_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (vic_vec[w]) victim_o = $clog2(WAYS)'(w);
        end
    end

endmodule

// File: rtl/cache_l1_nway.sv
// N-way set-associative write-back, write-allocate L1 cache with tree PLRU.
// Hits answer combinationally; misses run an optional writeback, then a fill.
module cache_l1_nway
    import rv32i_types::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = 32 - CACHE_OFFSET_W - IDX_W;

    cache_state_e state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  valid_d [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAYS-1:0]  dirty_d [SETS];
    logic [WAYS-2:0]  plru_q  [SETS];
    logic [WAYS-2:0]  plru_d  [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [TAG_W-1:0] tag_d   [SETS][WAYS];
    rv32i_cache_line  data_q  [SETS][WAYS];
    rv32i_cache_line  data_d  [SETS][WAYS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [2:0]       word_off;
    logic             addr_unused;
    logic             req;

    assign idx         = mem_address[CACHE_OFFSET_W +: IDX_W];
    assign tag         = mem_address[31 -: TAG_W];
    assign word_off    = mem_address[4:2];
    assign addr_unused = ^mem_address[1:0];
    assign req         = mem_read | mem_write;

    logic [WAYS-1:0]  hit_vec;
    logic [WAYS-1:0]  valid_set;
    logic [WAYS-1:0]  dirty_set;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_any;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] plru_victim;
    logic [WAY_W-1:0] miss_way;
    logic [WAYS-2:0]  plru_upd;
    rv32i_cache_line  hit_line;
    rv32i_cache_line  merged_line;

    assign valid_set = valid_q[idx];
    assign dirty_set = dirty_q[idx];

    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign hit_vec[w] = valid_set[w] && (tag_q[idx][w] == tag);
    end

    assign hit     = |hit_vec;
    assign inv_any = ~&valid_set;

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_set[w]) inv_way = WAY_W'(w);
        end
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .nodes_i      (plru_q[idx]),
        .access_way_i (hit_way),
        .nodes_o      (plru_upd),
        .victim_o     (plru_victim)
    );

    assign miss_way = inv_any ? inv_way : plru_victim;
    assign hit_line = data_q[idx][hit_way];

    always_comb begin
        merged_line = hit_line;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                merged_line[{word_off, 2'(b), 3'b000} +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_CMP;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            plru_q   <= plru_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        unique case (state_q)
            ST_CMP: begin
                if (req && !hit) begin
                    victim_d = miss_way;
                    state_d  = dirty_set[miss_way] ? ST_WB : ST_FILL;
                end
            end
            ST_WB:   if (pmem_resp) state_d = ST_FILL;
            ST_FILL: if (pmem_resp) state_d = ST_CMP;
            default: state_d = ST_CMP;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state_q)
            ST_CMP: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    if (mem_read) mem_rdata = hit_line[{word_off, 5'b00000} +: 32];
                end
            end
            ST_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx][victim_q], idx, {CACHE_OFFSET_W{1'b0}}};
                pmem_wdata   = data_q[idx][victim_q];
            end
            ST_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {tag, idx, {CACHE_OFFSET_W{1'b0}}};
            end
            default: ;
        endcase
    end

    // Only the indexed set and the hit or victim way ever change.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        plru_d  = plru_q;
        tag_d   = tag_q;
        data_d  = data_q;
        unique case (state_q)
            ST_CMP: begin
                if (req && hit) begin
                    plru_d[idx] = plru_upd;
                    if (mem_write) begin
                        data_d[idx][hit_way]  = merged_line;
                        dirty_d[idx][hit_way] = 1'b1;
                    end
                end
            end
            ST_WB: begin
                if (pmem_resp) dirty_d[idx][victim_q] = 1'b0;
            end
            ST_FILL: begin
                if (pmem_resp) begin
                    data_d[idx][victim_q]  = pmem_rdata;
                    tag_d[idx][victim_q]   = tag;
                    valid_d[idx][victim_q] = 1'b1;
                    dirty_d[idx][victim_q] = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_l1_nway.sv
// Directed bench for cache_l1_nway (SETS=8, WAYS=4) with a fixed-latency
// line memory that answers pmem requests on the third cycle.
module tb_cache_l1_nway;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    cache_l1_nway #(.SETS(8), .WAYS(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [255:0] mem [logic [31:0]];
    bit           log_wr   [$];
    logic [31:0]  log_addr [$];
    logic [255:0] log_data [$];

    // Untouched line at A holds word i = 0x1000_0000 + A + 4*i.
    function automatic logic [255:0] pattern(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'h1000_0000 + a + 32'(4 * i);
        return l;
    endfunction

    function automatic logic [31:0] pw(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pattern(a);
    endfunction

    initial begin
        int cnt;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (rst || !(pmem_read || pmem_write)) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 3) begin
                    cnt       = 0;
                    pmem_resp = 1'b1;
                    log_wr.push_back(pmem_write);
                    log_addr.push_back(pmem_address);
                    log_data.push_back(pmem_wdata);
                    if (pmem_write) mem[pmem_address] = pmem_wdata;
                    else pmem_rdata = line_of(pmem_address);
                end
            end
        end
    end

    task automatic clear_log();
        log_wr.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic cpu(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output int cyc);
        @(negedge clk);
        mem_address     = a;
        mem_wdata       = wd;
        mem_byte_enable = be;
        mem_read        = !wr;
        mem_write       = wr;
        #1;
        cyc = 0;
        while (!mem_resp && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        rd = mem_rdata;
        check("resp_seen", mem_resp, 1);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_d, input int exp_cyc);
        logic [31:0] d;
        int c;
        cpu(1'b0, a, 32'h0, 4'h0, d, c);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_lat"}, c, exp_cyc);
    endtask

    task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int exp_cyc);
        logic [31:0] d;
        int c;
        cpu(1'b1, a, wd, be, d, c);
        check({tag, "_lat"}, c, exp_cyc);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l40;
        logic [255:0] merged;
        int n;
        int wcount;

        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        l40             = pattern(32'h40);
        l40[95:64]      = 32'hDEADBEEF;
        mem[32'h40]     = l40;
        merged          = l40;
        merged[95:64]   = 32'hDEAD3344;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_resp", mem_resp, 0);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_pmem_addr", pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_log();

        // Cold fill, hit latency, byte-masked write, dirty eviction.
        rd_chk("cold_40", 32'h40, pw(32'h40), 4);
        check("cold_nlog", log_wr.size(), 1);
        check("cold_addr", log_addr[0], 32'h40);
        check("cold_is_rd", log_wr[0], 0);
        rd_chk("hit_48", 32'h48, 32'hDEADBEEF, 0);
        check("hit_nlog", log_wr.size(), 1);
        wr_chk("wr_48", 32'h48, 32'h11223344, 4'b0011, 0);
        rd_chk("rd_merged", 32'h48, 32'hDEAD3344, 0);
        rd_chk("fill_140", 32'h140, pw(32'h140), 4);
        rd_chk("fill_240", 32'h240, pw(32'h240), 4);
        rd_chk("fill_340", 32'h344, pw(32'h344), 4);
        n = log_wr.size();
        rd_chk("dirty_440", 32'h440, pw(32'h440), 7);
        check("dirty_nlog", log_wr.size(), n + 2);
        if (log_wr.size() == n + 2) begin
            check("wb_is_wr", log_wr[n], 1);
            check("wb_addr", log_addr[n], 32'h40);
            check("wb_data", log_data[n], merged);
            check("fill_is_rd", log_wr[n+1], 0);
            check("fill_addr", log_addr[n+1], 32'h440);
        end
        rd_chk("refetch_48", 32'h48, 32'hDEAD3344, 4);

        // Reset while a writeback is outstanding.
        do_reset();
        wr_chk("d_wr_40", 32'h40, 32'hCAFEF00D, 4'b1111, 4);
        rd_chk("d_140", 32'h140, pw(32'h140), 4);
        rd_chk("d_240", 32'h240, pw(32'h240), 4);
        rd_chk("d_340", 32'h340, pw(32'h340), 4);
        @(negedge clk);
        mem_address = 32'h440;
        mem_read    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (pmem_write) break;
        end
        check("d_wb_seen", pmem_write, 1);
        check("d_wb_addr", pmem_address, 32'h40);
        rst = 1'b1;
        #1;
        check("d_rst_pwrite", pmem_write, 0);
        check("d_rst_pread", pmem_read, 0);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        rd_chk("d_lost_40", 32'h40, pw(32'h40), 4);
        check("d_nlog", log_wr.size(), 1);
        check("d_refill_rd", log_wr[0], 0);
        check("d_refill_addr", log_addr[0], 32'h40);

        // Five clean tags in set 2: the fifth replaces way 0 without writeback.
        do_reset();
        rd_chk("a_040", 32'h040, pw(32'h040), 4);
        rd_chk("a_140", 32'h140, pw(32'h140), 4);
        rd_chk("a_240", 32'h240, pw(32'h240), 4);
        rd_chk("a_340", 32'h340, pw(32'h340), 4);
        rd_chk("a_440", 32'h440, pw(32'h440), 4);
        wcount = 0;
        foreach (log_wr[i]) wcount += int'(log_wr[i]);
        check("a_nlog", log_wr.size(), 5);
        check("a_no_wb", wcount, 0);
        rd_chk("a_hit_140", 32'h140, pw(32'h140), 0);
        rd_chk("a_hit_440", 32'h440, pw(32'h440), 0);
        rd_chk("a_miss_040", 32'h040, pw(32'h040), 4);

        // A hit on way 0 steers the next victim to way 2.
        do_reset();
        rd_chk("b_040", 32'h040, pw(32'h040), 4);
        rd_chk("b_140", 32'h140, pw(32'h140), 4);
        rd_chk("b_240", 32'h240, pw(32'h240), 4);
        rd_chk("b_340", 32'h340, pw(32'h340), 4);
        rd_chk("b_hit_040", 32'h040, pw(32'h040), 0);
        rd_chk("b_440", 32'h440, pw(32'h440), 4);
        rd_chk("b_keep_040", 32'h040, pw(32'h040), 0);
        rd_chk("b_keep_140", 32'h140, pw(32'h140), 0);
        rd_chk("b_keep_340", 32'h340, pw(32'h340), 0);
        rd_chk("b_gone_240", 32'h240, pw(32'h240), 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
